// File: rtl/fetch_queue_if.sv
// Handshake bundle between instruction fetch, the fetch queue and decode.
interface fetch_queue_if #(
  parameter int unsigned DEPTH = 4
);
  logic                     in_valid;
  logic [63:0]              in_pc;
  logic [31:0]              in_instr;
  logic                     in_error;
  logic                     in_ready;
  logic                     out_valid;
  logic [63:0]              out_pc;
  logic [31:0]              out_instr;
  logic                     out_error;
  logic                     out_ready;
  logic [$clog2(DEPTH):0]   count;
  logic                     stall_fetch;

  modport master (
    output in_valid, in_pc, in_instr, in_error, out_ready,
    input  in_ready, out_valid, out_pc, out_instr, out_error, count, stall_fetch
  );

  modport slave (
    input  in_valid, in_pc, in_instr, in_error, out_ready,
    output in_ready, out_valid, out_pc, out_instr, out_error, count, stall_fetch
  );
endinterface

// File: rtl/fetch_queue.sv
// Circular instruction queue between fetch and decode; flush discards all entries.
module fetch_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  fetch_queue_if.slave  bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [63:0]   pc_mem_q    [DEPTH];
  logic [31:0]   instr_mem_q [DEPTH];
  logic          error_mem_q [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic          push;
  logic          pop;
  logic          in_ready;
  logic          out_valid;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    in_ready        = (count_q != CW'(DEPTH));
    out_valid       = (count_q != '0);
    bus.in_ready    = in_ready;
    bus.out_valid   = out_valid;
    bus.out_pc      = pc_mem_q[head_q];
    bus.out_instr   = instr_mem_q[head_q];
    bus.out_error   = error_mem_q[head_q];
    bus.count       = count_q;
    bus.stall_fetch = (count_q >= CW'(DEPTH - 1));
  end

  always_comb begin
    push    = bus.in_valid && in_ready && !flush;
    pop     = out_valid && bus.out_ready && !flush;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = ptr_inc(tail_q);
      if (pop)  head_d = ptr_inc(head_q);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage is deliberately unreset; contents are only observed while out_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[tail_q]    <= bus.in_pc;
      instr_mem_q[tail_q] <= bus.in_instr;
      error_mem_q[tail_q] <= bus.in_error;
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a scoreboard queue of expected head entries.
module tb_fetch_queue;
  localparam int unsigned DEPTH = 4;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        err;
  } entry_t;

  logic clk;
  logic reset;
  logic flush;

  int unsigned n_checks;
  int unsigned n_fail;
  entry_t      sb[$];

  fetch_queue_if #(.DEPTH(DEPTH)) bus ();

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] instr_of(input logic [63:0] pc);
    return pc[31:0] ^ 32'h5A5A_0013;
  endfunction

  // One clock: drive inputs, check outputs at negedge against the model, then advance the model.
  task automatic step(input logic v, input logic [63:0] pc, input logic [31:0] ins,
                      input logic err, input logic ordy, input logic fl, input logic rst,
                      input string tag);
    int unsigned mcount;
    bit          pop_ok;
    bit          push_ok;
    entry_t      e;
    bus.in_valid  = v;
    bus.in_pc     = pc;
    bus.in_instr  = ins;
    bus.in_error  = err;
    bus.out_ready = ordy;
    flush         = fl;
    reset         = rst;
    @(negedge clk);
    mcount = sb.size();
    chk({tag, ".count"},     64'(bus.count),       64'(mcount));
    chk({tag, ".in_ready"},  64'(bus.in_ready),    64'(mcount != DEPTH));
    chk({tag, ".stall"},     64'(bus.stall_fetch), 64'(mcount >= DEPTH - 1));
    chk({tag, ".out_valid"}, 64'(bus.out_valid),   64'(mcount != 0));
    if (mcount != 0) begin
      chk({tag, ".out_pc"},    bus.out_pc,            sb[0].pc);
      chk({tag, ".out_instr"}, 64'(bus.out_instr),    64'(sb[0].instr));
      chk({tag, ".out_error"}, 64'(bus.out_error),    64'(sb[0].err));
    end
    if (rst || fl) begin
      sb.delete();
    end else begin
      pop_ok  = ordy && (mcount != 0);
      push_ok = v && (mcount != DEPTH);
      if (pop_ok) void'(sb.pop_front());
      if (push_ok) begin
        e.pc = pc; e.instr = ins; e.err = err;
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string tag);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, tag);
  endtask

  task automatic push_pc(input logic [63:0] pc, input string tag);
    step(1'b1, pc, instr_of(pc), 1'b0, 1'b0, 1'b0, 1'b0, tag);
  endtask

  initial begin
    logic [63:0] pc;
    n_checks = 0;
    n_fail   = 0;
    bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_instr = '0; bus.in_error = 1'b0;
    bus.out_ready = 1'b0; flush = 1'b0; reset = 1'b1;

    // Reset: outputs before the first edge are undefined, so just clock through.
    @(posedge clk); #1;
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b1, "reset");
    idle("after_reset");
    chk("reset.in_ready_const", 64'(bus.in_ready), 64'd1);

    // Fill with out_ready low, then attempt a fifth push while full.
    for (int i = 0; i < 4; i++) push_pc(64'h8000_0000 + 64'(4 * i), "fill");
    chk("fill.count_full", 64'(bus.count), 64'd4);
    push_pc(64'h8000_0010, "fifth_push");
    chk("fill.count_still_full", 64'(bus.count), 64'd4);

    // Push while full and popping: push must be blocked.
    step(1'b1, 64'h8000_0ABC, instr_of(64'h8000_0ABC), 1'b0, 1'b1, 1'b0, 1'b0, "full_push_pop");
    chk("full_push_pop.count", 64'(bus.count), 64'd3);

    // Drain.
    for (int i = 0; i < 4; i++)
      step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0, "drain");
    chk("drain.empty_count", 64'(bus.count), 64'd0);
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0, "pop_on_empty");

    // Streaming across multiple pointer wraps.
    pc = 64'h8000_2000;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, pc, instr_of(pc), 1'b0, 1'b1, 1'b0, 1'b0, "stream");
      pc += 64'd4;
    end
    chk("stream.count_one", 64'(bus.count), 64'd1);
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0, "stream_tail");

    // Flush with 3 queued entries, concurrent push and pop discarded.
    for (int i = 0; i < 3; i++) push_pc(64'h8000_0100 + 64'(4 * i), "pre_flush");
    step(1'b1, 64'h8000_1000, instr_of(64'h8000_1000), 1'b0, 1'b1, 1'b1, 1'b0, "flush");
    chk("flush.count_zero", 64'(bus.count), 64'd0);
    chk("flush.out_valid", 64'(bus.out_valid), 64'd0);
    idle("post_flush");
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, "flush_empty");

    // Fault passthrough.
    step(1'b1, 64'h8000_0002, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 1'b0, "fault_push");
    push_pc(64'h8000_0008, "after_fault");
    chk("fault.out_error", 64'(bus.out_error), 64'd1);
    chk("fault.out_instr", 64'(bus.out_instr), 64'h0000_0000_DEAD_BEEF);
    for (int i = 0; i < 2; i++)
      step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0, "fault_drain");

    // Reset mid-stream with 2 entries.
    push_pc(64'h8000_3000, "pre_reset");
    push_pc(64'h8000_3004, "pre_reset");
    step(1'b1, 64'h8000_3008, instr_of(64'h8000_3008), 1'b0, 1'b1, 1'b1, 1'b1, "mid_reset");
    chk("mid_reset.count", 64'(bus.count), 64'd0);
    chk("mid_reset.in_ready", 64'(bus.in_ready), 64'd1);
    push_pc(64'h8000_4000, "post_reset_push");
    chk("post_reset.head_pc", bus.out_pc, 64'h8000_4000);
    chk("post_reset.count", 64'(bus.count), 64'd1);
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0, "final_drain");
    idle("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
